core_data_bus: RTL

- Responder end of the core's data-memory request interface (`ram_*` signals driven by the mem stage).
- Decodes each request to one of three targets:
  - word-organised data RAM with byte lanes;
  - CLINT-style timer block (mtime/mtimecmp);
  - unmapped space.
- Returns read data combinationally in the same cycle, as the mem stage requires.
- Drives `timer_irq_o` to the interrupt unit's `timer_interrupt_i`.

---
 rtl/core_data_bus_pkg.sv | 50 +++++
 rtl/core_data_bus_clint_timer.sv | 90 +++++++++
 rtl/core_data_bus.sv | 106 ++++++++++
 3 files changed

// File: rtl/core_data_bus_pkg.sv
// Shared constants and lane helpers for the core data bus and its CLINT timer block.
package core_data_bus_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [15:0] MSIP_OFS        = 16'h0000;
   localparam logic [15:0] MTIMECMP_LO_OFS = 16'h4000;
   localparam logic [15:0] MTIMECMP_HI_OFS = 16'h4004;
   localparam logic [15:0] MTIME_LO_OFS    = 16'hBFF8;
   localparam logic [15:0] MTIME_HI_OFS    = 16'hBFFC;

   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
      logic [31:0] sh;
      logic [31:0] r;
      sh = word >> {lane, 3'b000};
      case (f3)
         F3_LB:   r = {{24{sh[7]}}, sh[7:0]};
         F3_LH:   r = {{16{sh[15]}}, sh[15:0]};
         F3_LW:   r = sh;
         F3_LBU:  r = {24'h0, sh[7:0]};
         F3_LHU:  r = {16'h0, sh[15:0]};
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [3:0]  be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = data[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/core_data_bus_clint_timer.sv
// CLINT-style timer: prescaled 64-bit mtime, mtimecmp, registered compare interrupt.
// SOC_MSIP_EN adds the msip register and soft_irq_o.
module core_data_bus_clint_timer
   import core_data_bus_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wr_en,
   input  logic [13:0] word_ofs,
   input  logic [3:0]  be,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        hit,
`ifdef SOC_MSIP_EN
   output logic        soft_irq_o,
`endif
   output logic        timer_irq_o
);
   localparam int            PW          = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESCALE_TC = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_cnt;
   logic          tick;
   logic [63:0]   mtime, mtime_nxt, mtimecmp, mtimecmp_nxt;
   logic          sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi, sel_msip;
   logic          msip;

   assign sel_cmp_lo = word_ofs == MTIMECMP_LO_OFS[15:2];
   assign sel_cmp_hi = word_ofs == MTIMECMP_HI_OFS[15:2];
   assign sel_mt_lo  = word_ofs == MTIME_LO_OFS[15:2];
   assign sel_mt_hi  = word_ofs == MTIME_HI_OFS[15:2];
   assign hit        = sel_cmp_lo | sel_cmp_hi | sel_mt_lo | sel_mt_hi | sel_msip;

   // Down-counter reloads at terminal count; starting at the reload value keeps
   // the first tick PRESCALE cycles after reset.
   assign tick = presc_cnt == '0;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) presc_cnt <= PRESCALE_TC;
      else        presc_cnt <= tick ? PRESCALE_TC : presc_cnt - 1'b1;
   end

   always_comb begin
      mtime_nxt    = mtime;
      mtimecmp_nxt = mtimecmp;
      if (wr_en && sel_mt_lo)      mtime_nxt[31:0]     = byte_merge(mtime[31:0], wdata, be);
      else if (wr_en && sel_mt_hi) mtime_nxt[63:32]    = byte_merge(mtime[63:32], wdata, be);
      else if (tick)               mtime_nxt           = mtime + 64'd1;
      if (wr_en && sel_cmp_lo)     mtimecmp_nxt[31:0]  = byte_merge(mtimecmp[31:0], wdata, be);
      if (wr_en && sel_cmp_hi)     mtimecmp_nxt[63:32] = byte_merge(mtimecmp[63:32], wdata, be);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mtime       <= '0;
         mtimecmp    <= '1;
         timer_irq_o <= 1'b0;
      end else begin
         mtime       <= mtime_nxt;
         mtimecmp    <= mtimecmp_nxt;
         timer_irq_o <= mtime >= mtimecmp;
      end
   end

`ifdef SOC_MSIP_EN
   assign sel_msip = word_ofs == MSIP_OFS[15:2];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                          msip <= 1'b0;
      else if (wr_en && sel_msip && be[0]) msip <= wdata[0];
   end

   assign soft_irq_o = msip;
`else
   assign sel_msip = 1'b0;
   assign msip     = 1'b0;
`endif

   always_comb begin
      rdata = '0;
      if (sel_cmp_lo) rdata = mtimecmp[31:0];
      if (sel_cmp_hi) rdata = mtimecmp[63:32];
      if (sel_mt_lo)  rdata = mtime[31:0];
      if (sel_mt_hi)  rdata = mtime[63:32];
      if (sel_msip)   rdata = {31'h0, msip};
   end

endmodule

// File: rtl/core_data_bus.sv
// Data-memory responder for the mem stage: decodes requests onto the byte-lane data RAM
// and the CLINT timer. Define SOC_MSIP_EN to add the msip register and soft_irq_o.
module core_data_bus
   import core_data_bus_pkg::*;
#(
   parameter int          RAM_DEPTH  = 4096,
   parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
   parameter int          PRESCALE   = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  ram_request_o,
   input  logic                  ram_we_o,
   input  logic [3:0]            ram_op_o,
   input  logic [ADDR_WIDTH-1:0] ram_addr_o,
   input  logic [DATA_WIDTH-1:0] ram_wdata_o,
   output logic [DATA_WIDTH-1:0] ram_rdata_i,
   output logic                  timer_irq_o,
`ifdef SOC_MSIP_EN
   output logic                  soft_irq_o,
`endif
   output logic                  bus_err_o
);
   localparam int                    IDX_W     = $clog2(RAM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] RAM_BYTES = ADDR_WIDTH'(RAM_DEPTH * 4);

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
   logic [IDX_W-1:0]      ram_idx;
   logic [2:0]            f3;
   logic                  unused_op_rsvd;
   logic                  op_ok, align_ok, ram_hit, clint_win, clint_hit, acc_ok;
   logic                  ram_wr, clint_wr;
   logic [3:0]            be;
   logic [31:0]           wlane, ram_word, clint_word, sel_word;

   assign f3             = ram_op_o[2:0];
   assign unused_op_rsvd = ram_op_o[3];
   assign ram_idx        = ram_addr_o[IDX_W+1:2];
   assign ram_word       = mem[ram_idx];
   assign ram_hit        = ram_addr_o < RAM_BYTES;
   assign clint_win      = ram_addr_o[31:16] == CLINT_BASE[31:16];

   always_comb begin
      op_ok = ram_we_o ? (f3 <= F3_SW) : !(f3 inside {3'b011, 3'b110, 3'b111});
      case (f3[1:0])
         2'b00:   align_ok = 1'b1;
         2'b01:   align_ok = !ram_addr_o[0];
         2'b10:   align_ok = ram_addr_o[1:0] == 2'b00;
         default: align_ok = 1'b0;
      endcase
   end

   assign acc_ok = ram_request_o && op_ok && align_ok && (ram_hit || (clint_win && clint_hit));

   // Narrow stores are replicated across lanes so the byte enables alone pick the target.
   always_comb begin
      case (f3[1:0])
         2'b00: begin
            be    = 4'b0001 << ram_addr_o[1:0];
            wlane = {4{ram_wdata_o[7:0]}};
         end
         2'b01: begin
            be    = 4'b0011 << {ram_addr_o[1], 1'b0};
            wlane = {2{ram_wdata_o[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wlane = ram_wdata_o;
         end
      endcase
   end

   assign ram_wr   = rst_i && acc_ok && ram_we_o && ram_hit;
   assign clint_wr = acc_ok && ram_we_o && !ram_hit;
   assign sel_word = ram_hit ? ram_word : clint_word;

   assign ram_rdata_i = (rst_i && acc_ok && !ram_we_o)
                        ? load_extend(sel_word, ram_addr_o[1:0], f3) : '0;

   always_ff @(posedge clk_i) begin
      if (ram_wr) mem[ram_idx] <= byte_merge(ram_word, wlane, be);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) bus_err_o <= 1'b0;
      else        bus_err_o <= ram_request_o && !acc_ok;
   end

   core_data_bus_clint_timer #(
      .PRESCALE (PRESCALE)
   ) u_clint_timer (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .wr_en       (clint_wr),
      .word_ofs    (ram_addr_o[15:2]),
      .be          (be),
      .wdata       (wlane),
      .rdata       (clint_word),
      .hit         (clint_hit),
`ifdef SOC_MSIP_EN
      .soft_irq_o  (soft_irq_o),
`endif
      .timer_irq_o (timer_irq_o)
   );

endmodule
